// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle execute controller (operand read, ALU, data memory, writeback).
// Optional retired-instruction counter enabled by defining EXEC_CTRL_PERF_EN.
module exec_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [2:0]  inst_op,
  input  logic [2:0]  inst_rs,
  input  logic [2:0]  inst_rt,
  output logic [2:0]  rf_ra_addr,
  output logic [2:0]  rf_rb_addr,
  input  logic [7:0]  rf_ra_data,
  input  logic [7:0]  rf_rb_data,
  output logic [2:0]  alu_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_zero,
  output logic        dm_req,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wdata,
  input  logic        dm_ack,
  input  logic [7:0]  dm_rdata,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        branch_taken,
  output logic        mem_err,
  output logic [15:0] perf_retired
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OPRD = 3'd1,
    EXEC = 3'd2,
    MEM  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam logic [2:0] OP_BEQ = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t state, nxt;

  logic [2:0]    op_q, rs_q, rt_q;
  logic [2:0]    cmd_q;
  logic [7:0]    a_q, b_q, r_q;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          mem_last;
  logic          is_ld, is_st, is_beq;

  assign is_ld    = (op_q == OP_LD);
  assign is_st    = (op_q == OP_ST);
  assign is_beq   = (op_q == OP_BEQ);
  assign mem_last = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic; an ack on the final MEM cycle beats the timeout
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (inst_valid) nxt = OPRD;
      OPRD: nxt = EXEC;
      EXEC: begin
        if (is_ld || is_st) nxt = MEM;
        else if (is_beq)    nxt = IDLE;
        else                nxt = WB;
      end
      MEM: begin
        if (dm_ack)        nxt = is_st ? IDLE : WB;
        else if (mem_last) nxt = IDLE;
      end
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: instruction latch, operands, result, timeout counter, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      cmd_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inst_valid) begin
            op_q <= inst_op;
            rs_q <= inst_rs;
            rt_q <= inst_rt;
          end
        end
        OPRD: begin
          a_q   <= rf_ra_data;
          b_q   <= rf_rb_data;
          cmd_q <= op_q;
        end
        EXEC: begin
          r_q <= alu_rslt;
          cnt <= '0;
        end
        MEM: begin
          if (dm_ack) begin
            if (is_ld) r_q <= dm_rdata;
          end else if (mem_last) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; handshake strobes only inside their own states
  always_comb begin
    inst_ready   = (state == IDLE);
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    dm_addr      = '0;
    dm_wdata     = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    branch_taken = 1'b0;
    unique case (state)
      EXEC: branch_taken = is_beq && alu_zero;
      MEM: begin
        dm_req   = 1'b1;
        dm_we    = is_st;
        dm_addr  = r_q;
        dm_wdata = a_q;
      end
      WB: begin
        rf_we    = 1'b1;
        rf_waddr = rs_q;
        rf_wdata = r_q;
      end
      default: ;
    endcase
  end

  assign rf_ra_addr = rs_q;
  assign rf_rb_addr = rt_q;
  assign alu_cmd    = cmd_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign mem_err    = err_q;

`ifdef EXEC_CTRL_PERF_EN
  logic        retire;
  logic [15:0] perf_q;

  assign retire = (state == WB)
                | ((state == MEM) && dm_ack && is_st)
                | ((state == EXEC) && is_beq);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      perf_q <= '0;
    else if (retire) perf_q <= perf_q + 16'd1;
  end

  assign perf_retired = perf_q;
`else
  assign perf_retired = '0;
`endif

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles a data-memory request waits for dm_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inst_valid  input  1  decoded instruction offered; inst_ready  output  1  block accepts instruction.
REQ-005 inst_op  input  3  ALU command code (000 add .. 111 rtl); inst_rs, inst_rt  input  3 each  register indices.
REQ-006 rf_ra_addr, rf_rb_addr  output  3 each  regfile read addresses; rf_ra_data, rf_rb_data  input  8 each  combinational read data.
REQ-007 alu_cmd  output  3, alu_a, alu_b  output  8 each  ALU operands; alu_rslt  input  8, alu_zero  input  1  ALU result/zero flag.
REQ-008 dm_req  output  1, dm_we  output  1, dm_addr  output  8, dm_wdata  output  8, dm_ack  input  1, dm_rdata  input  8  data-memory handshake.
REQ-009 rf_we  output  1, rf_waddr  output  3, rf_wdata  output  8  regfile writeback.
REQ-010 branch_taken  output  1  one-cycle pulse on equal compare; mem_err  output  1  sticky memory-timeout flag; perf_retired  output  16  retired-instruction count.

Function
REQ-011 FSM states IDLE, OPRD, EXEC, MEM, WB; inst_ready SHALL equal (state==IDLE).
REQ-012 IDLE: inst_valid high -> latch op/rs/rt, go OPRD; else stay.
REQ-013 OPRD: drive rf_ra_addr=rs, rf_rb_addr=rt; capture rf_ra_data/rf_rb_data into operand registers A/B; go EXEC.
REQ-014 EXEC: drive alu_cmd=op, alu_a=A, alu_b=B; capture alu_rslt into R and alu_zero into Z.
REQ-015 EXEC exit: op 101 (load) or 110 (store) -> MEM; op 011 (beq) -> IDLE with branch_taken=1 that cycle iff alu_zero; all other ops -> WB.
REQ-016 MEM: dm_req=1, dm_addr=R, dm_we=(op==110), dm_wdata=A; held stable until dm_ack sampled high.
REQ-017 MEM with dm_ack: load -> capture dm_rdata into R, go WB; store -> go IDLE.
REQ-018 MEM timeout counter SHALL clear on MEM entry, increment each MEM cycle without ack; on reaching MEM_TIMEOUT without ack -> set mem_err, go IDLE, no writeback.
REQ-019 dm_ack in the same cycle the counter reaches MEM_TIMEOUT SHALL win (transaction completes, mem_err unchanged).
REQ-020 WB: rf_we=1 for exactly one cycle, rf_waddr=rs, rf_wdata=R; go IDLE.
REQ-021 Latency: ALU op accepted cycle N -> rf_we in N+3, inst_ready again N+4; beq -> inst_ready N+3.
REQ-022 Outside their states: dm_req, dm_we, rf_we, branch_taken SHALL be 0; alu_cmd/operand outputs hold last values.
REQ-023 dm_ack outside MEM SHALL be ignored; inst_valid outside IDLE SHALL be ignored.
REQ-024 mem_err SHALL clear only on reset.
REQ-025 All 8-bit data paths pass through unmodified; no sign extension or width change.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, A/B/R/Z/latched fields/counters to 0, all outputs to 0 except inst_ready=1.
REQ-027 Reset mid-MEM SHALL drop dm_req asynchronously; no writeback or branch pulse for the aborted instruction.
REQ-028 First instruction SHALL be accepted on the first rising edge after rst_n deasserts with inst_valid high.

Configuration
REQ-029 Macro EXEC_CTRL_PERF_EN defined: perf_retired increments (wrapping 16'hFFFF -> 0) once per instruction completing via WB, store ack, or beq exit; timeouts not counted.
REQ-030 Macro undefined: perf_retired port present, constant 0, no counter logic.

Verification
REQ-031 Add: rs=1 holds 8'h05, rt=2 holds 8'h03, op 000 -> rf_we one cycle at N+3, rf_waddr=1, rf_wdata=8'h08.
REQ-032 Beq: rs=rt=8'h2A, op 011 -> branch_taken pulse at N+2, no rf_we, inst_ready at N+3; unequal values -> no pulse.
REQ-033 Load: rt holds 8'h10, dm_ack after 3 wait cycles with dm_rdata=8'hC3 -> dm_addr=8'h10, dm_we=0, rf_wdata=8'hC3.
REQ-034 Store with dm_ack never asserted -> dm_req high exactly MEM_TIMEOUT cycles, mem_err=1, no rf_we, returns IDLE.
REQ-035 rst_n pulled low during MEM -> dm_req 0 immediately, inst_ready 1, mem_err 0, no writeback afterward.
REQ-036 With EXEC_CTRL_PERF_EN, 3 ALU ops + 1 timed-out store -> perf_retired=3; without macro -> 0.
